level_memory: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline plus the MEM/WB pipeline register that feeds the write-back stage. It holds the word-organised data memory and performs sw/sh/sb byte-lane writes and lw/lh/lhu/lb/lbu extraction with sign or zero extension. It registers the instruction, pc+8, ALU result, loaded data and destination register number toward write-back. It supports pipeline stall and flush, and flags misaligned accesses.

---
 rtl/level_memory_pkg.sv | 39 +++
 rtl/level_memory_if.sv | 30 +++
 rtl/data_mem.sv | 30 +++
 rtl/level_memory.sv | 136 +++++++++++++
 tb/tb_level_memory.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/level_memory_pkg.sv
// Shared MIPS definitions for the MEM stage: load/store opcodes, access kinds and the nop word.
// Purely declarative; no timing or flow-control behaviour of its own.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [2:0] {LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_kind_e;
  typedef enum logic [1:0] {ST_NONE, ST_W, ST_H, ST_B} st_kind_e;

  function automatic ld_kind_e ld_kind(input logic [5:0] op);
    case (op)
      OP_LW:   return LD_W;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      default: return LD_NONE;
    endcase
  endfunction

  function automatic st_kind_e st_kind(input logic [5:0] op);
    case (op)
      OP_SW:   return ST_W;
      OP_SH:   return ST_H;
      OP_SB:   return ST_B;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/level_memory_if.sv
// MEM-stage request bundle and MEM/WB result bundle; the master drives the stage, the slave is the stage.
// No handshake: stall/flush are the only flow control, sampled every rising edge.
interface level_memory_if;

  logic [31:0] Instr_in;
  logic [31:0] pc_add_8_in;
  logic [31:0] ALUResult;
  logic [31:0] Store_data;
  logic [4:0]  WriteRegNum;
  logic        stall;
  logic        flush;

  logic [31:0] Instr_out;
  logic [31:0] pc_add_8_out;
  logic [31:0] ALUResult_out;
  logic [31:0] DM_data_out;
  logic [4:0]  WriteRegNum_out;
  logic        addr_exc;

  modport master (
    output Instr_in, pc_add_8_in, ALUResult, Store_data, WriteRegNum, stall, flush,
    input  Instr_out, pc_add_8_out, ALUResult_out, DM_data_out, WriteRegNum_out, addr_exc
  );

  modport slave (
    input  Instr_in, pc_add_8_in, ALUResult, Store_data, WriteRegNum, stall, flush,
    output Instr_out, pc_add_8_out, ALUResult_out, DM_data_out, WriteRegNum_out, addr_exc
  );

endinterface

// File: rtl/data_mem.sv
// Word-organised data memory: byte-enable write on the rising edge, combinational read.
// Read latency 0, write commits at the edge; no backpressure, async clear of every word on reset.
module data_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/level_memory.sv
// MIPS MEM stage plus MEM/WB register: byte-lane stores, extended loads, misalignment flag.
// Latency 1 edge to MEM/WB; stall holds MEM/WB, flush inserts a bubble, both suppress the DM write.
module level_memory
  import mips_defs::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic           clk,
  input  logic           reset,
  level_memory_if.slave  bus
);

  ld_kind_e    ld;
  st_kind_e    st;
  logic [1:0]  off;
  logic        misaligned;
  logic        active;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ld_data;

  logic [31:0] instr_q;
  logic [31:0] pc8_q;
  logic [31:0] alu_q;
  logic [31:0] dm_q;
  logic [4:0]  rd_q;
  logic        exc_q;

  assign ld     = ld_kind(bus.Instr_in[31:26]);
  assign st     = st_kind(bus.Instr_in[31:26]);
  assign off    = bus.ALUResult[1:0];
  assign active = !bus.stall && !bus.flush;

  always_comb begin
    misaligned = 1'b0;
    if (ld == LD_W || st == ST_W)                    misaligned = (off != 2'b00);
    else if (ld == LD_H || ld == LD_HU || st == ST_H) misaligned = off[0];
  end

  // Narrow store data is replicated across lanes so only the byte enables steer placement.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.Store_data;
    case (st)
      ST_W: be = 4'b1111;
      ST_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.Store_data[15:0]}};
      end
      ST_B: begin
        be    = 4'b0001 << off;
        wdata = {4{bus.Store_data[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  assign we = (st != ST_NONE) && !misaligned && active;

  data_mem #(
    .WORDS (DM_WORDS),
    .AW    (DM_AW)
  ) u_dm (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .be    (be),
    .addr  (bus.ALUResult[DM_AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    case (off)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ld_data = '0;
    if (!misaligned) begin
      case (ld)
        LD_W:    ld_data = rdata;
        LD_H:    ld_data = {{16{sel_half[15]}}, sel_half};
        LD_HU:   ld_data = {16'h0, sel_half};
        LD_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
        LD_BU:   ld_data = {24'h0, sel_byte};
        default: ld_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP;
      pc8_q   <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      rd_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        instr_q <= NOP;
        pc8_q   <= '0;
        alu_q   <= '0;
        dm_q    <= '0;
        rd_q    <= '0;
      end else if (!bus.stall) begin
        instr_q <= bus.Instr_in;
        pc8_q   <= bus.pc_add_8_in;
        alu_q   <= bus.ALUResult;
        dm_q    <= ld_data;
        rd_q    <= bus.WriteRegNum;
      end
      // Sticky until reset; a stalled or flushed access is not architecturally performed.
      if (active && misaligned && (ld != LD_NONE || st != ST_NONE)) exc_q <= 1'b1;
    end
  end

  assign bus.Instr_out       = instr_q;
  assign bus.pc_add_8_out    = pc8_q;
  assign bus.ALUResult_out   = alu_q;
  assign bus.DM_data_out     = dm_q;
  assign bus.WriteRegNum_out = rd_q;
  assign bus.addr_exc        = exc_q;

endmodule

// File: tb/tb_level_memory.sv
// Directed bench for level_memory: hand-computed expectations for stores, extended loads, stall/flush, misalignment, reset.
// One check task scores every comparison.
module tb_level_memory;
  import mips_defs::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic [31:0] held_instr;
  logic [31:0] pc_cnt;

  level_memory_if mif ();

  level_memory #(
    .DM_WORDS (1024),
    .DM_AW    (10)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one MEM-stage op at the falling edge, then sample #1 after the next rising edge.
  task automatic step(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                      input logic [4:0] rd, input logic stl, input logic fl);
    @(negedge clk);
    pc_cnt              = pc_cnt + 32'd4;
    exp_instr           = {op, 5'd3, 5'd7, 16'h00A5};
    exp_pc              = pc_cnt;
    mif.Instr_in        = exp_instr;
    mif.pc_add_8_in     = exp_pc;
    mif.ALUResult       = addr;
    mif.Store_data      = sdata;
    mif.WriteRegNum     = rd;
    mif.stall           = stl;
    mif.flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd);
    step(op, addr, 32'h0, rd, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    step(op, addr, sdata, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    pc_cnt          = 32'h0040_0000;
    reset           = 1'b0;
    mif.Instr_in    = '0;
    mif.pc_add_8_in = '0;
    mif.ALUResult   = '0;
    mif.Store_data  = '0;
    mif.WriteRegNum = '0;
    mif.stall       = 1'b0;
    mif.flush       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", u_dut.bus.Instr_out, 32'h0);
    chk("rst_exc",   {31'h0, mif.addr_exc}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Word round-trip
    st(OP_SW, 32'h20, 32'h1234_5678);
    ld(OP_LW, 32'h20, 5'd9);
    chk("lw_word",  mif.DM_data_out, 32'h1234_5678);
    chk("lw_rd",    {27'h0, mif.WriteRegNum_out}, 32'd9);
    chk("lw_instr", mif.Instr_out, exp_instr);
    chk("lw_pc8",   mif.pc_add_8_out, exp_pc);
    chk("lw_alu",   mif.ALUResult_out, 32'h20);

    // Byte and half extension
    st(OP_SW, 32'h40, 32'h80FF_7F01);
    ld(OP_LB,  32'h43, 5'd1); chk("lb3",  mif.DM_data_out, 32'hFFFF_FF80);
    ld(OP_LBU, 32'h43, 5'd1); chk("lbu3", mif.DM_data_out, 32'h0000_0080);
    ld(OP_LB,  32'h40, 5'd1); chk("lb0",  mif.DM_data_out, 32'h0000_0001);
    ld(OP_LBU, 32'h41, 5'd1); chk("lbu1", mif.DM_data_out, 32'h0000_007F);
    ld(OP_LB,  32'h42, 5'd1); chk("lb2",  mif.DM_data_out, 32'hFFFF_FFFF);
    ld(OP_LH,  32'h42, 5'd1); chk("lh2",  mif.DM_data_out, 32'hFFFF_80FF);
    ld(OP_LHU, 32'h42, 5'd1); chk("lhu2", mif.DM_data_out, 32'h0000_80FF);
    ld(OP_LH,  32'h40, 5'd1); chk("lh0",  mif.DM_data_out, 32'h0000_7F01);

    // Partial stores; upper Store_data bits must not leak into other lanes
    st(OP_SW, 32'h40, 32'h0);
    st(OP_SB, 32'h41, 32'h1234_56AB);
    st(OP_SH, 32'h42, 32'h9999_CDEF);
    ld(OP_LW, 32'h40, 5'd2);
    chk("partial", mif.DM_data_out, 32'hCDEF_AB00);

    // Non-memory op captures zero load data
    step(6'b000000, 32'h77, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0);
    chk("alu_dm",  mif.DM_data_out, 32'h0);
    chk("alu_res", mif.ALUResult_out, 32'h77);

    // Stall holds MEM/WB and blocks the write; flush+stall gives a bubble
    ld(OP_LW, 32'h20, 5'd11);
    held_instr = exp_instr;
    step(OP_SW, 32'h60, 32'h55, 5'd0, 1'b1, 1'b0);
    chk("stall1_instr", mif.Instr_out, held_instr);
    step(OP_SW, 32'h60, 32'h55, 5'd0, 1'b1, 1'b0);
    chk("stall2_instr", mif.Instr_out, held_instr);
    chk("stall2_dm",    mif.DM_data_out, 32'h1234_5678);
    chk("stall2_rd",    {27'h0, mif.WriteRegNum_out}, 32'd11);
    step(OP_SW, 32'h60, 32'h55, 5'd0, 1'b1, 1'b1);
    chk("flush_instr", mif.Instr_out, 32'h0);
    chk("flush_pc8",   mif.pc_add_8_out, 32'h0);
    chk("flush_alu",   mif.ALUResult_out, 32'h0);
    chk("flush_rd",    {27'h0, mif.WriteRegNum_out}, 32'h0);
    ld(OP_LW, 32'h60, 5'd3);
    chk("stall_nowrite", mif.DM_data_out, 32'h0);

    // Address wraps modulo the memory depth
    st(OP_SW, 32'h0000_1020, 32'h0000_A5A5);
    ld(OP_LW, 32'h20, 5'd3);
    chk("wrap", mif.DM_data_out, 32'h0000_A5A5);

    // Misalignment: stalled access does not flag, a live one does and sticks
    st(OP_SW, 32'h60, 32'h1122_3344);
    step(OP_SW, 32'h62, 32'hDEAD, 5'd0, 1'b1, 1'b0);
    chk("mis_stalled_exc", {31'h0, mif.addr_exc}, 32'h0);
    st(OP_SW, 32'h62, 32'h0000_DEAD);
    chk("mis_sw_exc", {31'h0, mif.addr_exc}, 32'h1);
    ld(OP_LW, 32'h60, 5'd5);
    chk("mis_mem_kept", mif.DM_data_out, 32'h1122_3344);
    ld(OP_LH, 32'h61, 5'd5);
    chk("mis_lh_zero", mif.DM_data_out, 32'h0);
    ld(OP_LHU, 32'h62, 5'd5);
    chk("lhu_after_mis", mif.DM_data_out, 32'h0000_1122);
    chk("mis_sticky", {31'h0, mif.addr_exc}, 32'h1);

    // Asynchronous reset mid-cycle clears outputs and memory at once
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_dm",    mif.DM_data_out, 32'h0);
    chk("arst_instr", mif.Instr_out, 32'h0);
    chk("arst_pc8",   mif.pc_add_8_out, 32'h0);
    chk("arst_exc",   {31'h0, mif.addr_exc}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    ld(OP_LW, 32'h10, 5'd6);
    chk("post_rst_lw10", mif.DM_data_out, 32'h0);
    chk("post_rst_rd",   {27'h0, mif.WriteRegNum_out}, 32'd6);
    ld(OP_LW, 32'h20, 5'd6);
    chk("post_rst_lw20", mif.DM_data_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
